// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth operand loader and its multiplier.
package booth_pkg;

  localparam int BOOTH_WIDTH       = 8;
  localparam int BOOTH_SYNC_STAGES = 2;
  localparam int BOOTH_TIMEOUT     = 4 * BOOTH_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    LOAD_B = 3'b001,
    REQ    = 3'b010,
    BUSY   = 3'b011,
    SHOW   = 3'b100
  } loader_state_t;

  // Presses arriving while the multiplier owns the operands are reported as dropped.
  function automatic logic is_locked(loader_state_t s);
    return (s == REQ) || (s == BUSY);
  endfunction

endpackage

// File: rtl/booth_operand_loader_if.sv
// Switch/press inputs, multiplier handshake and display outputs of the operand loader.
interface booth_operand_loader_if #(
  parameter int WIDTH = booth_pkg::BOOTH_WIDTH
);

  logic [WIDTH-1:0]   sw;
  logic               press;
  logic               start_ready;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               start_valid;
  logic [2*WIDTH-1:0] result;
  logic [2:0]         stage;
  logic               timeout_err;
  logic               dropped;

  modport master (
    output sw, press, start_ready, mul_done, mul_product,
    input  op_a, op_b, start_valid, result, stage, timeout_err, dropped
  );

  modport slave (
    input  sw, press, start_ready, mul_done, mul_product,
    output op_a, op_b, start_valid, result, stage, timeout_err, dropped
  );

endinterface

// File: rtl/booth_operand_loader_sw_synchronizer.sv
// Per-bit flop chain bringing the raw switch word into the clock domain.
module sw_synchronizer #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [SYNC_STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/booth_operand_loader.sv
// Captures two switch operands on successive presses, hands them to the Booth
// multiplier over valid/ready and holds the product for display.
//
//   state  | meaning
//   IDLE   | waiting for the press that captures operand A
//   LOAD_B | waiting for the press that captures operand B
//   REQ    | operands offered to the multiplier (start_valid high)
//   BUSY   | multiplier running, timeout timer counting
//   SHOW   | product displayed until the next press
module booth_operand_loader
  import booth_pkg::*;
#(
  parameter int WIDTH       = BOOTH_WIDTH,
  parameter int SYNC_STAGES = BOOTH_SYNC_STAGES,
  parameter int TIMEOUT     = BOOTH_TIMEOUT
) (
  input logic             i_clk,
  input logic             i_rst_n,
  booth_operand_loader_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  loader_state_t      r_state, w_state_nxt;
  logic               r_press_q;
  logic [WIDTH-1:0]   r_op_a, w_op_a_nxt;
  logic [WIDTH-1:0]   r_op_b, w_op_b_nxt;
  logic [2*WIDTH-1:0] r_result, w_result_nxt;
  logic               r_start_valid, w_start_valid_nxt;
  logic               r_timeout_err, w_timeout_err_nxt;
  logic               r_dropped, w_dropped_nxt;
  logic [TW-1:0]      r_timer, w_timer_nxt;
  logic [WIDTH-1:0]   w_sw_sync;
  logic               w_press_evt;

  sw_synchronizer #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (bus.sw),
    .o_q     (w_sw_sync)
  );

  // A strobe held for several cycles must count as a single press.
  assign w_press_evt = bus.press & ~r_press_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_press_q     <= 1'b0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_result      <= '0;
      r_start_valid <= 1'b0;
      r_timeout_err <= 1'b0;
      r_dropped     <= 1'b0;
      r_timer       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_press_q     <= bus.press;
      r_op_a        <= w_op_a_nxt;
      r_op_b        <= w_op_b_nxt;
      r_result      <= w_result_nxt;
      r_start_valid <= w_start_valid_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_dropped     <= w_dropped_nxt;
      r_timer       <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_op_a_nxt        = r_op_a;
    w_op_b_nxt        = r_op_b;
    w_result_nxt      = r_result;
    w_timeout_err_nxt = r_timeout_err;
    w_timer_nxt       = r_timer;
    w_dropped_nxt     = w_press_evt & is_locked(r_state);

    case (r_state)
      IDLE: begin
        if (w_press_evt) begin
          w_op_a_nxt  = w_sw_sync;
          w_state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        if (w_press_evt) begin
          w_op_b_nxt  = w_sw_sync;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (r_start_valid && bus.start_ready) begin
          w_timer_nxt = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A completion on the expiry edge still counts as success.
        if (bus.mul_done) begin
          w_result_nxt = bus.mul_product;
          w_state_nxt  = SHOW;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = IDLE;
        end else if (r_timer < TW'(TIMEOUT)) begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      SHOW: begin
        if (w_press_evt) begin
          w_op_a_nxt        = w_sw_sync;
          w_op_b_nxt        = '0;
          w_timeout_err_nxt = 1'b0;
          w_state_nxt       = LOAD_B;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_start_valid_nxt = (w_state_nxt == REQ);
  end

  assign bus.op_a        = r_op_a;
  assign bus.op_b        = r_op_b;
  assign bus.result      = r_result;
  assign bus.start_valid = r_start_valid;
  assign bus.timeout_err = r_timeout_err;
  assign bus.dropped     = r_dropped;
  assign bus.stage       = (r_state > SHOW) ? IDLE : r_state;

endmodule
